// File: rtl/intr_apb_pkg.sv
// Shared sizes and types for the intr_ctrl APB initiator and its service agent.
package intr_apb_pkg;
   localparam int unsigned NUM_INTR = 16;
   localparam int unsigned ADDR_W   = $clog2(NUM_INTR);
   localparam int unsigned DATA_W   = 4;

   typedef enum logic [2:0] {
      ApbIdle   = 3'b001,
      ApbSetup  = 3'b010,
      ApbAccess = 3'b100
   } apb_state_e;

   typedef enum logic [1:0] {
      SvcIdle,
      SvcWait,
      SvcDone,
      SvcDrain
   } svc_state_e;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } apb_cmd_t;
endpackage

// File: rtl/intr_service_agent.sv
// Interrupt service agent: captures the pending id, waits SERVICE_CYCLES, pulses intr_serviced
// and counts completed services.
module intr_service_agent
   import intr_apb_pkg::*;
#(
   parameter int unsigned SERVICE_CYCLES = 4,
   parameter int unsigned CNT_W          = 8
) (
   input  logic              pclk,
   input  logic              prst,
   input  logic              intr_valid,
   input  logic [ADDR_W-1:0] intr_to_service,
   output logic              intr_serviced,
   output logic [ADDR_W-1:0] svc_id,
   output logic [CNT_W-1:0]  svc_count
);
   localparam int unsigned DlyW = $clog2(SERVICE_CYCLES + 1);

   svc_state_e        state_q, state_d;
   logic [DlyW-1:0]   dly_q, dly_d;
   logic [ADDR_W-1:0] id_q, id_d;
   logic [CNT_W-1:0]  count_q, count_d;

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q <= SvcIdle;
         dly_q   <= '0;
         id_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         id_q    <= id_d;
         count_q <= count_d;
      end
   end

   // The pulse lands SERVICE_CYCLES cycles after the cycle intr_valid is sampled in.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      id_d    = id_q;
      count_d = count_q;
      case (state_q)
         SvcIdle: begin
            if (intr_valid) begin
               id_d    = intr_to_service;
               dly_d   = DlyW'(SERVICE_CYCLES - 1);
               state_d = (SERVICE_CYCLES == 1) ? SvcDone : SvcWait;
            end
         end
         SvcWait: begin
            dly_d = dly_q - 1'b1;
            if (dly_q <= DlyW'(1)) state_d = SvcDone;
         end
         SvcDone: begin
            count_d = count_q + 1'b1;
            state_d = SvcDrain;
         end
         SvcDrain: begin
            if (!intr_valid) state_d = SvcIdle;
         end
         default: state_d = SvcIdle;
      endcase
   end

   assign intr_serviced = (state_q == SvcDone) && !prst;
   assign svc_id        = id_q;
   assign svc_count     = count_q;
endmodule

// File: rtl/apb_intr_initiator.sv
// APB initiator and interrupt-service agent for intr_ctrl.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_intr_initiator
   import intr_apb_pkg::*;
#(
   parameter int unsigned SERVICE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic              pclk,
   input  logic              prst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata,
   input  logic              intr_valid,
   input  logic [ADDR_W-1:0] intr_to_service,
   output logic              intr_serviced,
   output logic [ADDR_W-1:0] svc_id,
   output logic [CNT_W-1:0]  svc_count
);
   apb_state_e        state_q, state_d;
   apb_cmd_t          cmd_q, cmd_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              abort;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TmoW-1:0] tmo_q, tmo_d;

   always_ff @(posedge pclk) begin
      if (prst) tmo_q <= '0;
      else      tmo_q <= tmo_d;
   end

   always_comb begin
      tmo_d = '0;
      if (state_q == ApbAccess && !pready) tmo_d = tmo_q + 1'b1;
   end

   // Fires on the last of TIMEOUT_CYCLES consecutive ACCESS cycles without pready.
   assign abort = (state_q == ApbAccess) && !pready && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign abort          = 1'b0;
`endif

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q     <= ApbIdle;
         cmd_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      unique case (state_q)
         ApbIdle: begin
            if (cmd_valid) begin
               cmd_d   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
               state_d = ApbSetup;
            end
         end
         ApbSetup: state_d = ApbAccess;
         ApbAccess: begin
            if (pready) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = cmd_q.write ? '0 : prdata;
               state_d     = ApbIdle;
            end else if (abort) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               state_d     = ApbIdle;
            end
         end
         default: state_d = ApbIdle;
      endcase
   end

   // Combinational handshake outputs are held low while reset is applied.
   assign cmd_ready = (state_q == ApbIdle) && !prst;
   assign psel      = (state_q != ApbIdle) && !prst;
   assign penable   = (state_q == ApbAccess) && !prst;
   assign pwrite    = cmd_q.write;
   assign paddr     = cmd_q.addr;
   assign pwdata    = cmd_q.wdata;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

   intr_service_agent #(
      .SERVICE_CYCLES (SERVICE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_service (
      .pclk            (pclk),
      .prst            (prst),
      .intr_valid      (intr_valid),
      .intr_to_service (intr_to_service),
      .intr_serviced   (intr_serviced),
      .svc_id          (svc_id),
      .svc_count       (svc_count)
   );
endmodule

// File: tb/tb_apb_intr_initiator.sv
// Scoreboard bench for apb_intr_initiator with a small intr_ctrl APB slave model
// (registered pready, one wait state). Define APB_TIMEOUT_EN to add the timeout test.
module tb_apb_intr_initiator;
   logic       pclk = 1'b0;
   logic       prst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_write = 1'b0;
   logic [3:0] cmd_addr = '0;
   logic [3:0] cmd_wdata = '0;
   logic       cmd_ready, rsp_valid, rsp_err;
   logic [3:0] rsp_rdata;
   logic       psel, penable, pwrite;
   logic [3:0] paddr, pwdata;
   logic       pready;
   logic [3:0] prdata;
   logic       intr_valid = 1'b0;
   logic [3:0] intr_to_service = '0;
   logic       intr_serviced;
   logic [3:0] svc_id;
   logic [7:0] svc_count;

   logic       stall = 1'b0;
   logic [3:0] mem [16] = '{default: 4'h0};

   typedef struct packed {
      logic [3:0] rdata;
      logic       err;
   } rsp_t;

   rsp_t       rsp_q[$];
   logic [3:0] svc_q[$];
   rsp_t       mon_rsp;
   logic [3:0] mon_id;
   int         n_pass = 0;
   int         n_total = 0;

   apb_intr_initiator u_dut (
      .pclk            (pclk),
      .prst            (prst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_write       (cmd_write),
      .cmd_addr        (cmd_addr),
      .cmd_wdata       (cmd_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_rdata       (rsp_rdata),
      .rsp_err         (rsp_err),
      .psel            (psel),
      .penable         (penable),
      .pwrite          (pwrite),
      .paddr           (paddr),
      .pwdata          (pwdata),
      .pready          (pready),
      .prdata          (prdata),
      .intr_valid      (intr_valid),
      .intr_to_service (intr_to_service),
      .intr_serviced   (intr_serviced),
      .svc_id          (svc_id),
      .svc_count       (svc_count)
   );

   always #5 pclk = ~pclk;

   // intr_ctrl model: pready rises one cycle into ACCESS and drops right after.
   always @(posedge pclk) begin
      if (prst) begin
         pready <= 1'b0;
      end else begin
         pready <= psel && penable && !pready && !stall;
         if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
      end
   end
   assign prdata = mem[paddr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic fail_now(input string name, input int val);
      n_total++;
      $display("FAIL %s: got %0d, expected event within bound", name, val);
   endtask

   function automatic logic [31:0] all_outputs();
      return 32'({cmd_ready, rsp_valid, rsp_err, rsp_rdata, psel, penable, pwrite, paddr,
                  pwdata, intr_serviced, svc_id, svc_count});
   endfunction

   // Scoreboard monitor.
   always @(negedge pclk) begin
      if (!prst && rsp_valid) begin
         if (rsp_q.size() == 0) begin
            fail_now("unexpected_rsp_valid", 0);
         end else begin
            mon_rsp = rsp_q.pop_front();
            check("rsp_rdata", 32'(rsp_rdata), 32'(mon_rsp.rdata));
            check("rsp_err", 32'(rsp_err), 32'(mon_rsp.err));
         end
      end
      if (!prst && intr_serviced) begin
         if (svc_q.size() == 0) begin
            fail_now("unexpected_intr_serviced", 0);
         end else begin
            mon_id = svc_q.pop_front();
            check("svc_id", 32'(svc_id), 32'(mon_id));
         end
      end
   end

   // Latency counts cycles after the accept cycle; the slave adds one wait state.
   task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [3:0] d,
                           input logic [3:0] exp_rd, input bit chk_shape);
      int n;
      int lat;
      bit ready_low;
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge pclk);
         n++;
      end
      if (!cmd_ready) begin
         fail_now("cmd_ready_wait", n);
         cmd_valid = 1'b0;
         return;
      end
      rsp_q.push_back('{rdata: (wr ? 4'h0 : exp_rd), err: 1'b0});
      @(negedge pclk);
      cmd_valid = 1'b0;
      lat = 1;
      ready_low = 1'b1;
      while (!rsp_valid && lat < 40) begin
         if (cmd_ready) ready_low = 1'b0;
         if (chk_shape && lat == 1)
            check("setup_phase", 32'({psel, penable, pwrite, paddr, pwdata}),
                  32'({1'b1, 1'b0, wr, a, d}));
         if (chk_shape && lat == 2)
            check("access_phase", 32'({psel, penable}), 32'(2'b11));
         @(negedge pclk);
         lat++;
      end
      if (!rsp_valid) begin
         fail_now("rsp_valid_wait", lat);
      end else if (chk_shape) begin
         check("xfer_latency", 32'(lat), 32'd4);
         check("cmd_ready_low_in_xfer", 32'(ready_low), 32'd1);
      end
   endtask

   task automatic do_service(input logic [3:0] id, input logic [3:0] alt_id,
                             input logic [7:0] exp_cnt);
      int lat;
      @(negedge pclk);
      intr_valid = 1'b1;
      intr_to_service = id;
      svc_q.push_back(id);
      lat = 0;
      do begin
         @(negedge pclk);
         lat++;
         if (lat == 2) intr_to_service = alt_id;
      end while (!intr_serviced && lat < 20);
      intr_valid = 1'b0;
      if (!intr_serviced) begin
         fail_now("intr_serviced_wait", lat);
         return;
      end
      check("svc_latency", 32'(lat), 32'd4);
      @(negedge pclk);
      check("svc_pulse_one_cycle", 32'(intr_serviced), 32'd0);
      check("svc_count", 32'(svc_count), 32'(exp_cnt));
   endtask

   initial begin
      int runs;
      int low_run;
      int gap;
      int acc2;
      int n_acc;
      logic pen_prev;

      repeat (2) @(negedge pclk);
      check("reset_outputs", all_outputs(), 32'd0);
      prst = 1'b0;
      @(negedge pclk);
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

      // T1 write, T2 read back
      apb_xfer(1'b1, 4'd3, 4'd9, 4'd0, 1'b1);
      check("t1_landed", 32'(mem[3]), 32'd9);
      apb_xfer(1'b0, 4'd3, 4'd0, 4'd9, 1'b1);

      // T3 back-to-back writes with cmd_valid held
      @(negedge pclk);
      check("t3_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd1; cmd_wdata = 4'd4;
      rsp_q.push_back('{rdata: 4'h0, err: 1'b0});
      @(negedge pclk);
      cmd_addr = 4'd2; cmd_wdata = 4'd6;
      pen_prev = 1'b0; runs = 0; low_run = 0; gap = -1; acc2 = 0;
      for (int c = 0; c < 14; c++) begin
         if (acc2 == 1) begin
            cmd_valid = 1'b0;
            acc2 = 2;
         end
         if (penable && !pen_prev) begin
            runs++;
            if (runs == 2) gap = low_run;
         end
         low_run = penable ? 0 : low_run + 1;
         pen_prev = penable;
         if (acc2 == 0 && cmd_ready) begin
            rsp_q.push_back('{rdata: 4'h0, err: 1'b0});
            acc2 = 1;
         end
         @(negedge pclk);
      end
      cmd_valid = 1'b0;
      check("t3_second_accepted", 32'(acc2), 32'd2);
      check("t3_access_runs", 32'(runs), 32'd2);
      check("t3_penable_gap", 32'(gap), 32'd2);
      check("t3_mem1", 32'(mem[1]), 32'd4);
      check("t3_mem2", 32'(mem[2]), 32'd6);
      apb_xfer(1'b0, 4'd1, 4'd0, 4'd4, 1'b0);
      apb_xfer(1'b0, 4'd2, 4'd0, 4'd6, 1'b0);

      // T4 service of id 5 with priority[5]=7; id input changes mid-wait
      apb_xfer(1'b1, 4'd5, 4'd7, 4'd0, 1'b0);
      do_service(4'd5, 4'd9, 8'd1);
      // independent FSMs: transfer and service overlap
      fork
         apb_xfer(1'b1, 4'd7, 4'hA, 4'd0, 1'b1);
         do_service(4'd12, 4'd0, 8'd2);
      join
      apb_xfer(1'b0, 4'd7, 4'd0, 4'hA, 1'b0);
      apb_xfer(1'b0, 4'd5, 4'd0, 4'd7, 1'b0);

      // T5 reset while in ACCESS and S_WAIT
      stall = 1'b1;
      @(negedge pclk);
      check("t5_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd4; cmd_wdata = 4'd5;
      intr_valid = 1'b1; intr_to_service = 4'd3;
      @(negedge pclk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge pclk);
      check("t5_in_access", 32'({psel, penable}), 32'(2'b11));
      prst = 1'b1;
      @(negedge pclk);
      check("t5_reset_outputs", all_outputs(), 32'd0);
      intr_valid = 1'b0;
      stall = 1'b0;
      prst = 1'b0;
      repeat (10) @(negedge pclk);
      check("t5_write_dropped", 32'(mem[4]), 32'd0);
      check("t5_idle_after", 32'(cmd_ready), 32'd1);
      do_service(4'd6, 4'd6, 8'd1);

`ifdef APB_TIMEOUT_EN
      // T6 timeout abort after 16 ACCESS cycles
      stall = 1'b1;
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd3;
      rsp_q.push_back('{rdata: 4'h0, err: 1'b1});
      @(negedge pclk);
      cmd_valid = 1'b0;
      n_acc = 0;
      for (int c = 0; c < 60 && !rsp_valid; c++) begin
         if (penable) n_acc++;
         @(negedge pclk);
      end
      if (!rsp_valid) fail_now("t6_abort_wait", n_acc);
      check("t6_access_cycles", 32'(n_acc), 32'd16);
      @(negedge pclk);
      check("t6_back_idle", 32'({cmd_ready, psel, penable}), 32'(3'b100));
      stall = 1'b0;
`else
      n_acc = 0;
`endif

      repeat (4) @(negedge pclk);
      check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
      check("svc_queue_drained", 32'(svc_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
